crc_mem_loader: RTL and testbench



---
 rtl/crc_mem_loader_if.sv | 28 ++
 rtl/crc_mem_loader.sv | 176 +++++++++++++++++
 tb/tb_crc_mem_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/crc_mem_loader_if.sv
// Bus bundle between the CRC memory loader and its neighbours: input byte
// stream, memory write port and the crc_start/crc_rdy handshake.
interface crc_mem_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int CRC_W  = 16
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              crc_start;
  logic              crc_rdy;
  logic [CRC_W-1:0]  crc_in;

  // master is the loader; slave is the stream source / memory / sequencer side
  modport master (
    input  din, din_valid, crc_rdy, crc_in,
    output din_ready, mem_we, mem_addr, mem_wdata, crc_start
  );

  modport slave (
    output din, din_valid, crc_rdy, crc_in,
    input  din_ready, mem_we, mem_addr, mem_wdata, crc_start
  );
endinterface

// File: rtl/crc_mem_loader.sv
// Loads DEPTH stream words into the CRC data memory, pulses crc_start, then
// waits (with timeout) for the CRC sequencer and latches its result.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for load_start
// ST_LOAD     | accepting stream words and writing them to memory
// ST_KICK     | crc_start pulse; last memory write lands this cycle
// ST_WAIT_CRC | waiting for crc_rdy, bounded by TIMEOUT_CYC
// ST_DONE     | one-cycle done pulse, then back to idle
module crc_mem_loader #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,  // 2 .. 2**ADDR_W
  parameter int CRC_W       = 16,
  parameter int TIMEOUT_CYC = 8191
) (
  input  logic                 clk50m,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 abort,
  crc_mem_loader_if.master     bus,
  output logic [CRC_W-1:0]     crc_out,
  output logic                 crc_valid,
  output logic                 timeout_err,
  output logic                 busy,
  output logic                 done
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(DEPTH - 1);
  localparam logic [TMO_W-1:0]  LAST_TMO = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_WAIT_CRC,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              crc_start_q, crc_start_d;
  logic              done_q, done_d;
  logic [CRC_W-1:0]  crc_out_q, crc_out_d;
  logic              crc_valid_q, crc_valid_d;
  logic              timeout_err_q, timeout_err_d;

  logic din_ready_c;
  logic xfer_c;

  // abort wins over a same-cycle transfer by withdrawing ready
  assign din_ready_c = (state_q == ST_LOAD) && !abort;
  assign xfer_c      = bus.din_valid && din_ready_c;

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    crc_start_d   = 1'b0;
    done_d        = 1'b0;
    crc_out_d     = crc_out_q;
    crc_valid_d   = crc_valid_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          wr_cnt_d      = '0;
          crc_valid_d   = 1'b0;
          crc_out_d     = '0;
          timeout_err_d = 1'b0;
          state_d       = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          wr_cnt_d = '0;
          state_d  = ST_IDLE;
        end else if (xfer_c) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_cnt_q;
          mem_wdata_d = bus.din;
          // counter holds at the last address so it never wraps
          if (wr_cnt_q == LAST_WR) begin
            crc_start_d = 1'b1;
            state_d     = ST_KICK;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end

      ST_KICK: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT_CRC;
      end

      ST_WAIT_CRC: begin
        if (abort) begin
          wr_cnt_d = '0;
          state_d  = ST_IDLE;
        end else if (bus.crc_rdy) begin
          crc_out_d   = bus.crc_in;
          crc_valid_d = 1'b1;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end else if (tmo_cnt_q == LAST_TMO) begin
          timeout_err_d = 1'b1;
          done_d        = 1'b1;
          state_d       = ST_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_cnt_q      <= '0;
      tmo_cnt_q     <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      crc_start_q   <= 1'b0;
      done_q        <= 1'b0;
      crc_out_q     <= '0;
      crc_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      crc_start_q   <= crc_start_d;
      done_q        <= done_d;
      crc_out_q     <= crc_out_d;
      crc_valid_q   <= crc_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.din_ready = din_ready_c;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.crc_start = crc_start_q;

  assign crc_out     = crc_out_q;
  assign crc_valid   = crc_valid_q;
  assign timeout_err = timeout_err_q;
  assign done        = done_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_crc_mem_loader.sv
// Directed bench for crc_mem_loader: full loads, gapped stream, CRC capture,
// timeout, abort and mid-run reset.
module tb_crc_mem_loader;
  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 10;
  localparam int DEPTH       = 1024;
  localparam int CRC_W       = 16;
  localparam int TIMEOUT_CYC = 8191;

  logic             clk50m = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_start = 1'b0;
  logic             abort = 1'b0;
  logic [CRC_W-1:0] crc_out;
  logic             crc_valid;
  logic             timeout_err;
  logic             busy;
  logic             done;

  int n_chk = 0;
  int n_bad = 0;
  int mon_next = 0;
  int mon_cnt = 0;
  int mon_bad = 0;
  int n_start = 0;
  int n_done = 0;
  int cyc;

  crc_mem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CRC_W(CRC_W)) bus_if ();

  crc_mem_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .CRC_W(CRC_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk50m(clk50m), .rst_n(rst_n), .load_start(load_start), .abort(abort),
    .bus(bus_if), .crc_out(crc_out), .crc_valid(crc_valid),
    .timeout_err(timeout_err), .busy(busy), .done(done)
  );

  always #10 clk50m = ~clk50m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // one clock, sampled 1 ns after the edge; writes are checked for
  // contiguous addresses starting at mon_next and data == addr[7:0]
  task automatic tick();
    @(posedge clk50m);
    #1;
    if (bus_if.mem_we) begin
      if (int'(bus_if.mem_addr) != mon_next || bus_if.mem_wdata != mon_next[7:0]) mon_bad++;
      mon_next++;
      mon_cnt++;
    end
    if (bus_if.crc_start) n_start++;
    if (done) n_done++;
  endtask

  task automatic mon_clear();
    mon_next = 0;
    mon_cnt  = 0;
    mon_bad  = 0;
  endtask

  task automatic start_run();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // streams words stop_at words (din = word index), optionally gapped,
  // with an abort at word abort_at and a stray load_start at word ls_at
  task automatic run_load(input bit toggle, input int stop_at, input int abort_at,
                          input int ls_at);
    int w = 0;
    int c = 0;
    bit v;
    bit x;
    while (w < stop_at && c < 5000) begin
      v = toggle ? (c % 2 == 0) : 1'b1;
      bus_if.din       = w[7:0];
      bus_if.din_valid = v;
      abort            = v && (w == abort_at);
      load_start       = (w == ls_at);
      #1;
      x = v && bus_if.din_ready;
      if (abort) chk("abort_ready_low", bus_if.din_ready, 0);
      tick();
      load_start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        break;
      end
      if (x) w++;
      c++;
    end
  endtask

  initial begin
    bus_if.din       = '0;
    bus_if.din_valid = 1'b0;
    bus_if.crc_rdy   = 1'b0;
    bus_if.crc_in    = '0;
    repeat (3) @(negedge clk50m);

    chk("rst_busy", busy, 0);
    chk("rst_mem_we", bus_if.mem_we, 0);
    chk("rst_crc_start", bus_if.crc_start, 0);
    chk("rst_crc_out", crc_out, 0);
    chk("rst_crc_valid", crc_valid, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // run 1: continuous stream, CRC answer after ~3100 cycles
    mon_clear();
    start_run();
    chk("r1_busy", busy, 1);
    run_load(1'b0, DEPTH, -1, -1);
    chk("r1_writes", mon_cnt, DEPTH);
    chk("r1_order", mon_bad, 0);
    chk("r1_kick", bus_if.crc_start, 1);
    chk("r1_ready_after_last", bus_if.din_ready, 0);
    repeat (50) tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("r1_ls_ignored_busy", busy, 1);
    chk("r1_ls_ignored_ready", bus_if.din_ready, 0);
    repeat (3100 - 51) tick();
    bus_if.din_valid = 1'b0;
    chk("r1_no_extra_write", mon_cnt, DEPTH);
    chk("r1_one_start", n_start, 1);
    bus_if.crc_rdy = 1'b1;
    bus_if.crc_in  = 16'hBEEF;
    tick();
    bus_if.crc_rdy = 1'b0;
    bus_if.crc_in  = '0;
    chk("r1_done", done, 1);
    chk("r1_crc_out", crc_out, 16'hBEEF);
    chk("r1_crc_valid", crc_valid, 1);
    tick();
    chk("r1_done_1cyc", done, 0);
    chk("r1_idle", busy, 0);
    chk("r1_n_done", n_done, 1);
    chk("r1_hold_out", crc_out, 16'hBEEF);
    chk("r1_hold_valid", crc_valid, 1);

    // run 2: gapped stream, stray load_start mid-load, then timeout
    mon_clear();
    start_run();
    chk("r2_clr_valid", crc_valid, 0);
    chk("r2_clr_out", crc_out, 0);
    run_load(1'b1, DEPTH, -1, 300);
    bus_if.din_valid = 1'b0;
    chk("r2_writes", mon_cnt, DEPTH);
    chk("r2_order", mon_bad, 0);
    chk("r2_kick", bus_if.crc_start, 1);
    cyc = 0;
    while (!done && cyc < 9000) begin
      tick();
      cyc++;
    end
    chk("r2_tmo_cycles", cyc, 8192);
    chk("r2_timeout_err", timeout_err, 1);
    chk("r2_crc_valid", crc_valid, 0);
    tick();
    chk("r2_idle", busy, 0);
    chk("r2_hold_tmo", timeout_err, 1);
    chk("r2_n_done", n_done, 2);

    // run 3: abort on word 500
    mon_clear();
    start_run();
    chk("r3_clr_tmo", timeout_err, 0);
    run_load(1'b0, DEPTH, 500, -1);
    bus_if.din_valid = 1'b0;
    chk("r3_no_write", bus_if.mem_we, 0);
    chk("r3_idle", busy, 0);
    chk("r3_writes", mon_cnt, 500);
    chk("r3_order", mon_bad, 0);
    repeat (5) tick();
    chk("r3_no_start", n_start, 2);
    chk("r3_no_done", n_done, 2);

    // run 4: restart from address 0, reset asserted at word 200
    mon_clear();
    start_run();
    run_load(1'b0, 200, -1, -1);
    chk("r4_we_before_rst", bus_if.mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("r4_rst_we", bus_if.mem_we, 0);
    chk("r4_rst_busy", busy, 0);
    chk("r4_rst_ready", bus_if.din_ready, 0);
    chk("r4_writes", mon_cnt, 200);
    chk("r4_order", mon_bad, 0);
    bus_if.din_valid = 1'b0;
    @(negedge clk50m);
    rst_n = 1'b1;
    tick();
    chk("r4_idle_after_rst", busy, 0);
    chk("r4_total_starts", n_start, 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
